// File: rtl/unified_mem_arbiter.sv
// Arbitrates one single-ported unified memory between instruction fetch and data load/store.
// Optional MEM_TIMEOUT_EN adds a bounded wait for mem_ack with a sticky err flag.
module unified_mem_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int STARVE_MAX  = 4,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              busy,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, BUSY_D, BUSY_I, RESP} state_t;

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  state_t              state_q;
  logic [CNT_W-1:0]    starve_q, starve_d;
  logic                mem_req_q, mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic [DATA_W-1:0]   if_rdata_q, d_rdata_q;
  logic                if_ready_q, d_ready_q;
  logic                err_q;
  logic                grant_fetch_d;
  logic                timeout_d;
  logic                done_d;
  logic [DATA_W-1:0]   rdata_d;

`ifdef MEM_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] wait_q;
  assign timeout_d = (wait_q == TO_W'(TIMEOUT_CYC - 1));
`else
  assign timeout_d = 1'b0;
`endif

  // Fetch wins only when it is alone or has been passed over STARVE_MAX times.
  always_comb begin
    grant_fetch_d = if_req && (!d_req || (starve_q == STARVE_LIM));
    starve_d      = starve_q;
    if (grant_fetch_d) begin
      starve_d = '0;
    end else if (d_req && if_req && (starve_q != STARVE_LIM)) begin
      starve_d = starve_q + 1'b1;
    end
  end

  // mem_ack takes precedence over a coinciding timeout.
  always_comb begin
    done_d  = ((state_q == BUSY_D) || (state_q == BUSY_I)) && (mem_ack || timeout_d);
    rdata_d = mem_ack ? mem_rdata : DATA_W'(32'hDEAD_BEEF);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      starve_q    <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      if_ready_q  <= 1'b0;
      d_ready_q   <= 1'b0;
      err_q       <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      wait_q      <= '0;
`endif
    end else begin
      if_ready_q <= 1'b0;
      d_ready_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (if_req || d_req) begin
            mem_req_q <= 1'b1;
            starve_q  <= starve_d;
`ifdef MEM_TIMEOUT_EN
            wait_q    <= '0;
`endif
            if (grant_fetch_d) begin
              state_q     <= BUSY_I;
              mem_we_q    <= 1'b0;
              mem_addr_q  <= if_addr;
              mem_wdata_q <= '0;
            end else begin
              state_q     <= BUSY_D;
              mem_we_q    <= d_we;
              mem_addr_q  <= d_addr;
              mem_wdata_q <= d_wdata;
            end
          end
        end
        BUSY_D, BUSY_I: begin
          if (done_d) begin
            mem_req_q <= 1'b0;
            state_q   <= RESP;
            if (!mem_ack) begin
              err_q <= 1'b1;
            end
            if (state_q == BUSY_I) begin
              if_ready_q <= 1'b1;
              if_rdata_q <= rdata_d;
            end else begin
              d_ready_q <= 1'b1;
              if (!mem_we_q) begin
                d_rdata_q <= rdata_d;
              end
            end
          end
`ifdef MEM_TIMEOUT_EN
          else begin
            wait_q <= wait_q + 1'b1;
          end
`endif
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign if_ready  = if_ready_q;
  assign d_rdata   = d_rdata_q;
  assign d_ready   = d_ready_q;
  assign busy      = (state_q != IDLE);
`ifdef MEM_TIMEOUT_EN
  assign err       = err_q;
`else
  // err_q can never be set here; the TIMEOUT_CYC term only keeps the parameter referenced.
  assign err       = err_q & (TIMEOUT_CYC == 0);
`endif

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter: inputs change and outputs are checked on the falling edge.
module tb_unified_mem_arbiter;

  logic        clk;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ready;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        busy;
  logic        err;

  int checks   = 0;
  int failures = 0;

  unified_mem_arbiter #(
    .ADDR_W(32), .DATA_W(32), .STARVE_MAX(4), .TIMEOUT_CYC(16)
  ) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .busy(busy), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    int n;
    logic is_i;
    reset = 1'b0; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_addr = '0; d_wdata = '0; mem_rdata = '0; mem_ack = 1'b0;

    // Reset state
    tick(); tick();
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_if_rdata", if_rdata, 32'd0);
    check("rst_d_rdata", d_rdata, 32'd0);
    check("rst_readys", {30'd0, if_ready, d_ready}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    reset = 1'b1;

    // Zero-wait fetch
    tick();
    if_req = 1'b1; if_addr = 32'h0000_0040;
    tick();
    check("f_mem_req", {31'd0, mem_req}, 32'd1);
    check("f_mem_addr", mem_addr, 32'h0000_0040);
    check("f_mem_we", {31'd0, mem_we}, 32'd0);
    check("f_busy", {31'd0, busy}, 32'd1);
    mem_ack = 1'b1; mem_rdata = 32'h2002_0005;
    tick();
    check("f_if_ready", {31'd0, if_ready}, 32'd1);
    check("f_if_rdata", if_rdata, 32'h2002_0005);
    check("f_mem_req_drop", {31'd0, mem_req}, 32'd0);
    check("f_d_ready", {31'd0, d_ready}, 32'd0);
    if_req = 1'b0; mem_ack = 1'b0;
    tick();
    check("f_idle_busy", {31'd0, busy}, 32'd0);
    check("f_ready_pulse", {31'd0, if_ready}, 32'd0);

    // Store with three wait cycles
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h10; d_wdata = 32'hCAFE_F00D;
    for (int k = 1; k <= 4; k++) begin
      tick();
      check("s_mem_req", {31'd0, mem_req}, 32'd1);
      check("s_mem_we", {31'd0, mem_we}, 32'd1);
      check("s_mem_addr", mem_addr, 32'h10);
      check("s_mem_wdata", mem_wdata, 32'hCAFE_F00D);
      check("s_no_ready", {31'd0, d_ready}, 32'd0);
      if (k == 4) begin
        mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
      end
    end
    tick();
    check("s_d_ready", {31'd0, d_ready}, 32'd1);
    check("s_d_rdata_kept", d_rdata, 32'd0);
    d_req = 1'b0; mem_ack = 1'b0; d_we = 1'b0;
    tick();
    check("s_d_ready_pulse", {31'd0, d_ready}, 32'd0);
    check("s_idle", {31'd0, busy}, 32'd0);

    // Both requesters held: expect D,D,D,D,I,D,D,D,D,I
    if_req = 1'b1; if_addr = 32'h100; d_req = 1'b1; d_addr = 32'h200; d_wdata = '0;
    for (int g = 0; g < 10; g++) begin
      is_i = ((g % 5) == 4);
      tick();
      check("a_mem_req", {31'd0, mem_req}, 32'd1);
      check($sformatf("a_grant%0d", g), mem_addr, is_i ? 32'h100 : 32'h200);
      mem_ack = 1'b1; mem_rdata = 32'h1000 + g;
      tick();
      check($sformatf("a_if_ready%0d", g), {31'd0, if_ready}, {31'd0, is_i});
      check($sformatf("a_d_ready%0d", g), {31'd0, d_ready}, {31'd0, ~is_i});
      if (is_i) check("a_if_rdata", if_rdata, 32'h1000 + g);
      else      check("a_d_rdata", d_rdata, 32'h1000 + g);
      mem_ack = 1'b0;
      if (g == 9) begin
        if_req = 1'b0; d_req = 1'b0;
      end
      tick();
    end
    check("a_idle", {31'd0, busy}, 32'd0);

    // Asynchronous reset in the middle of BUSY_D
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h30;
    tick();
    check("r_mem_req", {31'd0, mem_req}, 32'd1);
    check("r_mem_addr", mem_addr, 32'h30);
    #2 reset = 1'b0;
    #1;
    check("r_mem_req_drop", {31'd0, mem_req}, 32'd0);
    check("r_busy_drop", {31'd0, busy}, 32'd0);
    check("r_d_ready", {31'd0, d_ready}, 32'd0);
    check("r_if_rdata_clr", if_rdata, 32'd0);
    check("r_mem_addr_clr", mem_addr, 32'd0);
    d_req = 1'b0; if_req = 1'b1; if_addr = 32'h44; mem_ack = 1'b1;
    tick(); tick();
    check("r_hold_idle", {31'd0, busy}, 32'd0);
    reset = 1'b1; mem_ack = 1'b0;
    tick();
    check("r_fresh_req", {31'd0, mem_req}, 32'd1);
    check("r_fresh_addr", mem_addr, 32'h44);
    check("r_fresh_we", {31'd0, mem_we}, 32'd0);
    check("r_no_stale", {30'd0, if_ready, d_ready}, 32'd0);
    mem_ack = 1'b1; mem_rdata = 32'h0000_00AB;
    tick();
    check("r_if_ready", {30'd0, if_ready, d_ready}, 32'd2);
    check("r_if_rdata", if_rdata, 32'h0000_00AB);
    if_req = 1'b0; mem_ack = 1'b0;
    tick();

    // Spurious ack while idle, then a load
    mem_ack = 1'b1; mem_rdata = 32'h55;
    tick();
    check("p_idle_busy", {31'd0, busy}, 32'd0);
    check("p_idle_ready", {30'd0, if_ready, d_ready}, 32'd0);
    check("p_idle_d_rdata", d_rdata, 32'd0);
    mem_ack = 1'b0; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20;
    tick();
    check("p_mem_addr", mem_addr, 32'h20);
    check("p_mem_we", {31'd0, mem_we}, 32'd0);
    mem_ack = 1'b1; mem_rdata = 32'h0000_0007;
    tick();
    check("p_d_ready", {30'd0, if_ready, d_ready}, 32'd1);
    check("p_d_rdata", d_rdata, 32'h0000_0007);
    d_req = 1'b0; mem_ack = 1'b0;
    tick();

`ifdef MEM_TIMEOUT_EN
    // Fetch that never gets an ack
    if_req = 1'b1; if_addr = 32'h80;
    tick();
    check("t_mem_req", {31'd0, mem_req}, 32'd1);
    n = 0;
    while (if_ready !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check("t_latency", n, 32'd16);
    check("t_if_rdata", if_rdata, 32'hDEAD_BEEF);
    check("t_err", {31'd0, err}, 32'd1);
    if_req = 1'b0;
    tick(); tick();
    check("t_err_sticky", {31'd0, err}, 32'd1);
    check("t_idle", {31'd0, busy}, 32'd0);
`else
    n = 0;
    check("t_err_zero", {31'd0, err}, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
